irq_priority_controller: RTL

IRQ_PRIORITY_CONTROLLER -- requirements
Module: irq_priority_controller

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_priority_controller_if.sv | 13 +
 rtl/prio_enc8.sv | 20 ++
 rtl/irq_priority_controller.sv | 109 ++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt priority controller.
package irq_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_priority_controller_if.sv
// Presentation / acceptance / end-of-service handshake between controller and CPU side.
interface irq_priority_controller_if;
  import irq_pkg::*;

  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic            irq_ready;
  logic            eoi;

  modport master (output irq_valid, output irq_id, input irq_ready, input eoi);
  modport slave  (input irq_valid, input irq_id, output irq_ready, output eoi);

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder; bit 7 has the highest priority.
module prio_enc8 (
  input  logic [irq_pkg::N_REQ-1:0] vec,
  output logic [irq_pkg::ID_W-1:0]  idx_c,
  output logic                      any_c
);

  // Ascending scan: the last set bit visited is the highest one.
  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    for (int i = 0; i < int'(irq_pkg::N_REQ); i++) begin
      if (vec[i]) begin
        idx_c = irq_pkg::ID_W'(i);
        any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_controller.sv
// Prioritised, non-nesting interrupt presenter with pending/in-service tracking.
// Define IRQ_EDGE_DETECT_EN for edge-latched pending bits; default is level mode.
module irq_priority_controller #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            mask,
  irq_priority_controller_if.master   irq,
  output logic [N_REQ-1:0]            pending,
  output logic [N_REQ-1:0]            in_service
);
  import irq_pkg::*;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] in_service_q, in_service_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             valid_q;
  logic             accept_c;
  logic [N_REQ-1:0] accept_mask_c;
  logic [N_REQ-1:0] eligible_c;
  logic [ID_W-1:0]  top_idx_c;
  logic             top_any_c;
`ifdef IRQ_EDGE_DETECT_EN
  logic [N_REQ-1:0] req_q;
`endif

  assign eligible_c = pending_q & ~mask;

  prio_enc8 u_prio_enc8 (
    .vec   (eligible_c),
    .idx_c (top_idx_c),
    .any_c (top_any_c)
  );

  // Next state; irq_id only moves on the IDLE->PRESENT transition.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    in_service_d = in_service_q;
    accept_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && top_any_c) begin
          state_d = PRESENT;
          id_d    = top_idx_c;
        end
      end
      PRESENT: begin
        if (irq.irq_ready) begin
          state_d      = SERVICE;
          accept_c     = 1'b1;
          in_service_d = N_REQ'(1) << id_q;
        end else if (!en) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq.eoi) begin
          state_d      = IDLE;
          in_service_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending update; a new edge on the accepted line re-arms it in the same cycle.
  always_comb begin
    accept_mask_c = accept_c ? (N_REQ'(1) << id_q) : '0;
`ifdef IRQ_EDGE_DETECT_EN
    pending_d = (pending_q & ~accept_mask_c) | (req & ~req_q);
`else
    pending_d = req & ~accept_mask_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      in_service_q <= '0;
      id_q         <= '0;
      valid_q      <= 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
      req_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      id_q         <= id_d;
      valid_q      <= (state_d == PRESENT);
`ifdef IRQ_EDGE_DETECT_EN
      req_q        <= req;
`endif
    end
  end

  assign irq.irq_valid = valid_q;
  assign irq.irq_id    = id_q;
  assign pending       = pending_q;
  assign in_service    = in_service_q;

endmodule
